// File: rtl/ras_spec_ctrl_pkg.sv
// Shared constants and types for the RAS speculation controller.
package ras_spec_ctrl_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_ADDI    = 3'b000;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd1;

    // Stage record layout: {pushed, popped}
    localparam int REC_PUSHED = 1;
    localparam int REC_POPPED = 0;

    typedef logic [1:0] rec_t;

    typedef struct packed {
        logic       call;
        logic       ret;
        logic       mv_ra;
        logic [4:0] rd;
    } dec_t;

endpackage

// File: rtl/ras_op_decode.sv
// Combinational classifier of a fetched instruction into call / ret / mv_ra.
module ras_op_decode
    import ras_spec_ctrl_pkg::*;
#(
    parameter logic [4:0] RA_REG     = REG_RA,
    parameter logic [4:0] ALT_RA_REG = 5'd5
) (
    input  logic [31:0] instr_i,
    input  logic [4:0]  ra_track_i,
    output dec_t        dec_o
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic        rd_is_link;

    assign opcode     = instr_i[6:0];
    assign rd         = instr_i[11:7];
    assign funct3     = instr_i[14:12];
    assign rs1        = instr_i[19:15];
    assign imm        = instr_i[31:20];
    assign rd_is_link = (rd == RA_REG) || (rd == ALT_RA_REG);

    assign dec_o.call  = ((opcode == OPC_JAL) || (opcode == OPC_JALR)) && rd_is_link;
    assign dec_o.ret   = (opcode == OPC_JALR) && (rd == REG_ZERO) && (rs1 == ra_track_i);
    assign dec_o.mv_ra = (opcode == OPC_OP_IMM) && (funct3 == F3_ADDI) && (imm == 12'd0)
                         && (rs1 == ra_track_i) && (rd != REG_ZERO);
    assign dec_o.rd    = rd;

endmodule

// File: rtl/ras_spec_ctrl.sv
// RAS speculation controller: IF push/pop issue plus ID/EX rollback tracking.
// Optional ra-track update of mv_ra moves is enabled by defining RAS_RA_TRACK_EN.
module ras_spec_ctrl
    import ras_spec_ctrl_pkg::*;
#(
    parameter logic [4:0] RA_REG     = REG_RA,
    parameter logic [4:0] ALT_RA_REG = 5'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        stall,
    input  logic        flush_id,
    input  logic        flush_ex,
    input  logic        kill_ex,
    input  logic [4:0]  ra_track,
    output logic        pop,
    output logic        push,
    output logic [31:0] pc_add_4,
    output logic        rollback_pop_id,
    output logic        rollback_push_id,
    output logic        rollback_push_ex,
    output logic        WR_ra_track_en,
    output logic [4:0]  WR_ra_track_data
);

    dec_t dec;
    rec_t if_act;
    rec_t id_q, id_d;
    rec_t ex_q, ex_d;
    logic go;

    ras_op_decode #(
        .RA_REG     (RA_REG),
        .ALT_RA_REG (ALT_RA_REG)
    ) u_decode (
        .instr_i    (if_instr),
        .ra_track_i (ra_track),
        .dec_o      (dec)
    );

    // IF stage: decode is gated by rst_n so every output is quiet in reset
    assign go       = rst_n & if_valid & ~stall & ~flush_id & ~flush_ex & ~kill_ex;
    assign push     = go & dec.call;
    assign pop      = go & dec.ret;
    assign pc_add_4 = rst_n ? (if_pc + 32'd4) : 32'd0;

    always_comb begin
        if_act             = '0;
        if_act[REC_PUSHED] = push;
        if_act[REC_POPPED] = pop;
    end

    assign rollback_pop_id  = rst_n & (flush_ex | kill_ex) & id_q[REC_POPPED];
    assign rollback_push_id = rst_n & (flush_ex | kill_ex) & id_q[REC_PUSHED];
    assign rollback_push_ex = rst_n & kill_ex & ex_q[REC_PUSHED];

`ifdef RAS_RA_TRACK_EN
    assign WR_ra_track_en   = go & dec.mv_ra;
    assign WR_ra_track_data = (go & dec.mv_ra) ? dec.rd : 5'd0;
`else
    logic unused_mv_ra;
    assign unused_mv_ra     = ^{dec.mv_ra, dec.rd};
    assign WR_ra_track_en   = 1'b0;
    assign WR_ra_track_data = 5'd0;
`endif

    // IF -> ID -> EX record advance; killed stages clear on the same edge
    always_comb begin
        id_d = stall ? id_q : if_act;
        ex_d = stall ? rec_t'(2'b00) : id_q;
        if (flush_ex) begin
            id_d = '0;
        end
        if (kill_ex) begin
            id_d = '0;
            ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q <= '0;
            ex_q <= '0;
        end else begin
            id_q <= id_d;
            ex_q <= ex_d;
        end
    end

endmodule

// File: tb/tb_ras_spec_ctrl.sv
// Directed bench for ras_spec_ctrl: decode vector table plus multi-cycle rollback sequences.
module tb_ras_spec_ctrl;

    localparam logic [31:0] JAL_X1     = 32'h0000_00EF;
    localparam logic [31:0] JAL_X5     = 32'h0000_02EF;
    localparam logic [31:0] JAL_X0     = 32'h0000_006F;
    localparam logic [31:0] RET_X1     = 32'h0000_8067;
    localparam logic [31:0] JALR_X0_X5 = 32'h0002_8067;
    localparam logic [31:0] JALR_X1_X6 = 32'h0003_00E7;
    localparam logic [31:0] ADDI_MV    = 32'h0000_8393;
    localparam logic [31:0] ADDI_IMM4  = 32'h0040_8393;
    localparam logic [31:0] ADDI_X0    = 32'h0000_8013;
`ifdef RAS_RA_TRACK_EN
    localparam bit TRK = 1'b1;
`else
    localparam bit TRK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        stall;
    logic        flush_id;
    logic        flush_ex;
    logic        kill_ex;
    logic [4:0]  ra_track;
    logic        pop;
    logic        push;
    logic [31:0] pc_add_4;
    logic        rollback_pop_id;
    logic        rollback_push_id;
    logic        rollback_push_ex;
    logic        WR_ra_track_en;
    logic [4:0]  WR_ra_track_data;

    int checks = 0;
    int errors = 0;

    ras_spec_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_valid         (if_valid),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .stall            (stall),
        .flush_id         (flush_id),
        .flush_ex         (flush_ex),
        .kill_ex          (kill_ex),
        .ra_track         (ra_track),
        .pop              (pop),
        .push             (push),
        .pc_add_4         (pc_add_4),
        .rollback_pop_id  (rollback_pop_id),
        .rollback_push_id (rollback_push_id),
        .rollback_push_ex (rollback_push_ex),
        .WR_ra_track_en   (WR_ra_track_en),
        .WR_ra_track_data (WR_ra_track_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        st, fid, fex, kill;
        logic [4:0]  ra;
        logic        e_push, e_pop;
        logic [31:0] e_pc4;
        logic        e_wen;
        logic [4:0]  e_wdata;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                input logic st, input logic fid, input logic fex, input logic kl,
                                input logic [4:0] ra, input logic ep, input logic eo,
                                input logic [31:0] e4, input logic ew, input logic [4:0] ewd);
        vec_t r;
        r.valid = v;  r.instr = ins; r.pc = pc;
        r.st = st;    r.fid = fid;   r.fex = fex; r.kill = kl; r.ra = ra;
        r.e_push = ep; r.e_pop = eo; r.e_pc4 = e4; r.e_wen = ew; r.e_wdata = ewd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs after the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic r, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fid, input logic fex, input logic kl);
        @(negedge clk);
        rst_n = r; if_valid = v; if_instr = ins; if_pc = pc;
        stall = st; flush_id = fid; flush_ex = fex; kill_ex = kl;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_rb(input string tag, input logic e_pop_id, input logic e_push_id,
                            input logic e_push_ex);
        check({tag, " rb_pop_id"},  {31'd0, rollback_pop_id},  {31'd0, e_pop_id});
        check({tag, " rb_push_id"}, {31'd0, rollback_push_id}, {31'd0, e_push_id});
        check({tag, " rb_push_ex"}, {31'd0, rollback_push_ex}, {31'd0, e_push_ex});
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        stall = 1'b0; flush_id = 1'b0; flush_ex = 1'b0; kill_ex = 1'b0; ra_track = 5'd1;

        vecs[0]  = mk(1, JAL_X1,     32'h100,       0,0,0,0, 5'd1, 1,0, 32'h104,  0,   5'd0);
        vecs[1]  = mk(1, RET_X1,     32'h200,       0,0,0,0, 5'd1, 0,1, 32'h204,  0,   5'd0);
        vecs[2]  = mk(1, JALR_X1_X6, 32'h10,        0,0,0,0, 5'd1, 1,0, 32'h14,   0,   5'd0);
        vecs[3]  = mk(1, JAL_X5,     32'hFFFF_FFFC, 0,0,0,0, 5'd1, 1,0, 32'h0,    0,   5'd0);
        vecs[4]  = mk(1, JAL_X0,     32'h1000,      0,0,0,0, 5'd1, 0,0, 32'h1004, 0,   5'd0);
        vecs[5]  = mk(1, JALR_X0_X5, 32'h20,        0,0,0,0, 5'd1, 0,0, 32'h24,   0,   5'd0);
        vecs[6]  = mk(1, JALR_X0_X5, 32'h24,        0,0,0,0, 5'd5, 0,1, 32'h28,   0,   5'd0);
        vecs[7]  = mk(0, RET_X1,     32'h30,        0,0,0,0, 5'd1, 0,0, 32'h34,   0,   5'd0);
        vecs[8]  = mk(1, JAL_X1,     32'h40,        1,0,0,0, 5'd1, 0,0, 32'h44,   0,   5'd0);
        vecs[9]  = mk(1, JAL_X1,     32'h44,        0,1,0,0, 5'd1, 0,0, 32'h48,   0,   5'd0);
        vecs[10] = mk(1, RET_X1,     32'h48,        0,0,1,0, 5'd1, 0,0, 32'h4C,   0,   5'd0);
        vecs[11] = mk(1, JAL_X1,     32'h4C,        0,0,0,1, 5'd1, 0,0, 32'h50,   0,   5'd0);
        vecs[12] = mk(1, ADDI_MV,    32'h50,        0,0,0,0, 5'd1, 0,0, 32'h54,   TRK, TRK ? 5'd7 : 5'd0);
        vecs[13] = mk(1, ADDI_IMM4,  32'h54,        0,0,0,0, 5'd1, 0,0, 32'h58,   0,   5'd0);
        vecs[14] = mk(1, ADDI_X0,    32'h58,        0,0,0,0, 5'd1, 0,0, 32'h5C,   0,   5'd0);
        vecs[15] = mk(1, ADDI_MV,    32'h5C,        1,0,0,0, 5'd1, 0,0, 32'h60,   0,   5'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            ra_track = vecs[i].ra;
            drive(1'b1, vecs[i].valid, vecs[i].instr, vecs[i].pc,
                  vecs[i].st, vecs[i].fid, vecs[i].fex, vecs[i].kill);
            check($sformatf("v%0d push", i),    {31'd0, push},            {31'd0, vecs[i].e_push});
            check($sformatf("v%0d pop", i),     {31'd0, pop},             {31'd0, vecs[i].e_pop});
            check($sformatf("v%0d pc_add_4", i), pc_add_4,                vecs[i].e_pc4);
            check($sformatf("v%0d wr_en", i),   {31'd0, WR_ra_track_en},  {31'd0, vecs[i].e_wen});
            check($sformatf("v%0d wr_data", i), {27'd0, WR_ra_track_data}, {27'd0, vecs[i].e_wdata});
        end
        ra_track = 5'd1;

        // Reset: everything quiet even with a call in IF and kill_ex raised
        drive(1'b0, 1'b1, JAL_X1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst push", {31'd0, push}, 32'd0);
        check("rst pc_add_4", pc_add_4, 32'd0);
        check_rb("rst", 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, ADDI_MV, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst wr_en", {31'd0, WR_ra_track_en}, 32'd0);
        idle();

        // Call enters ID, kill_ex exposes the ID push once
        drive(1'b1, 1'b1, JAL_X1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        check("call push", {31'd0, push}, 32'd1);
        check("call pc_add_4", pc_add_4, 32'h104);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rb("call kill", 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rb("call kill2", 1'b0, 1'b0, 1'b0);
        idle();

        // flush_ex with a call in ID and another in IF
        drive(1'b1, 1'b1, JAL_X1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, JAL_X1, 32'h204, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fex push", {31'd0, push}, 32'd0);
        check_rb("fex", 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_rb("fex2", 1'b0, 1'b0, 1'b0);
        idle();
        idle();

        // Call in EX, ret in ID, kill_ex
        drive(1'b1, 1'b1, JAL_X5, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
        check("k push", {31'd0, push}, 32'd1);
        drive(1'b1, 1'b1, RET_X1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
        check("k pop", {31'd0, pop}, 32'd1);
        check("k push0", {31'd0, push}, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rb("kill", 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rb("kill2", 1'b0, 1'b0, 1'b0);
        idle();

        // Stall for 3 cycles with a call held in IF and one already in ID
        drive(1'b1, 1'b1, JAL_X1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, JAL_X1, 32'h504, 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("stall%0d push", c), {31'd0, push}, 32'd0);
        end
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_rb("stall kill", 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, JAL_X1, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0);
        check("release push", {31'd0, push}, 32'd1);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("release push once", {31'd0, push}, 32'd0);
        check_rb("release kill", 1'b0, 1'b1, 1'b0);
        idle();

        // Reset mid-flight discards a pending ID rollback
        drive(1'b1, 1'b1, JAL_X1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rb("midrst", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rb("midrst after", 1'b0, 1'b0, 1'b0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ras_spec_ctrl.md
# ras_spec_ctrl

Speculation controller for the return-address stack: decodes the fetched instruction in IF and issues RAS push/pop for calls and returns. Carries each instruction's RAS action down the IF→ID→EX pipeline and issues the matching rollback strobes when those instructions are flushed. Sits directly upstream of the RAS and drives all of its control inputs. Receives the predicted top-of-stack link register back from it.

## Interface
Parameters:
- `RA_REG`, 5'd1: primary link register (x1).
- `ALT_RA_REG`, 5'd5: alternate link register (x5), also treated as a link for call detection.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `if_valid` in 1: IF holds a valid instruction.
- `if_instr` in 32: fetched instruction.
- `if_pc` in 32: PC of the fetched instruction.
- `stall` in 1: freezes IF and ID; EX receives a bubble.
- `flush_id` in 1: ID-resolved redirect; kills the IF instruction.
- `flush_ex` in 1: EX-resolved redirect; kills the IF and ID instructions.
- `kill_ex` in 1: trap in EX; kills EX, ID and IF instructions.
- `ra_track` in 5: register currently holding the return address (from RAS).
- `pop` out 1: RAS pop.
- `push` out 1: RAS push.
- `pc_add_4` out 32: push data, `if_pc + 4`, wraps mod 2^32.
- `rollback_pop_id` out 1: undo the pop made by the ID instruction.
- `rollback_push_id` out 1: undo the push made by the ID instruction.
- `rollback_push_ex` out 1: undo the push made by the EX instruction.
- `WR_ra_track_en` out 1: update the RAS ra-track entry.
- `WR_ra_track_data` out 5: new ra-track register.

## Operation
- Instruction classes, decoded in IF:
  - call: JAL, or JALR, with rd ∈ {RA_REG, ALT_RA_REG}.
  - ret: JALR with rd = x0 and rs1 = `ra_track`.
  - mv_ra: ADDI with imm = 0, rs1 = `ra_track`, rd ≠ x0.
  - All other instructions: none.
- `go` = `if_valid` & !`stall` & !`flush_id` & !`flush_ex` & !`kill_ex`.
- `push` = `go` & call. `pop` = `go` & ret. `push` and `pop` are never both high.
- Stage records are 2 bits each, {pushed, popped}, one for ID and one for EX.
- When !`stall`, records advance: ID ← IF action masked by `go`; EX ← ID record.
- When `stall`, ID holds and EX ← 0.
- Any flush or kill clears the killed stage records on the same edge. `flush_id` clears nothing already recorded.
- `flush_ex`:
  - `rollback_pop_id` = ID.popped; `rollback_push_id` = ID.pushed.
  - ID record cleared. EX record advances normally.
- `kill_ex`:
  - Rollbacks for ID as with `flush_ex`, plus `rollback_push_ex` = EX.pushed.
  - ID and EX records cleared.
  - An EX pop is not restored; the RAS has no such path, so the entry loss is accepted.
- `rollback_push_ex` is never asserted without `kill_ex`.
- Rollback strobes are combinational from the records and last exactly one cycle; the records clear on the next edge.
- Priority: `kill_ex` > `flush_ex` > `flush_id` > `stall`.

## Timing
- `push`, `pop` and `pc_add_4` are combinational from IF inputs, sampled by the RAS at the same edge the instruction leaves IF.
- Rollback strobes are asserted in the cycle the flush or kill input is high.
- `WR_ra_track_en` is asserted in the cycle an mv_ra leaves IF with `go` high.
- Reset:
  - Both stage records become 0.
  - All outputs are 0 while `rst_n` = 0 (IF decode is gated by `rst_n`).
  - A reset mid-flight discards pending rollbacks.

## Configuration
- `RAS_RA_TRACK_EN` defined:
  - mv_ra decode is active.
  - `WR_ra_track_en` = `go` & mv_ra; `WR_ra_track_data` = rd.
- `RAS_RA_TRACK_EN` undefined:
  - `WR_ra_track_en` and `WR_ra_track_data` are tied to 0.
  - ret detection still uses the `ra_track` input.

## Structure
- Shared package/define file holds: opcode constants JAL = 7'b1101111, JALR = 7'b1100111, OP_IMM = 7'b0010011; the `ra` register constant; the record bit positions.
- Sub-module `ras_op_decode`: purely combinational; (`if_instr`, `ra_track`) → {call, ret, mv_ra, rd}.

## Test plan
- JAL x1 at `if_pc` = 0x100, no stall → `push` = 1 and `pc_add_4` = 0x104 in that cycle; ID.pushed = 1 one cycle later.
- `ra_track` = 1, JALR x0, 0(x1), no stall → `pop` = 1 and `push` = 0.
- JAL x1 reaches ID, then `flush_ex` → `rollback_push_id` = 1 for one cycle; a JAL x1 simultaneously in IF gives `push` = 0.
- JAL x5 in EX, ret in ID, `kill_ex` → `rollback_push_ex` = 1 and `rollback_pop_id` = 1 in the same cycle; both records are 0 afterwards.
- `stall` high for 3 cycles with a call in IF → `push` = 0 while stalled; EX record 0; a single push on release.
- With `RAS_RA_TRACK_EN`, `ra_track` = 1, ADDI x7, x1, 0 → `WR_ra_track_en` = 1 and `WR_ra_track_data` = 7. Without the macro → both are 0.
